conv_result_writer: RTL and testbench
=====================================

# conv_result_writer

Downstream stage of the convolution engine: accepts the stream of finished convolution results (one `DATA_W`-bit value per handshake), buffers them in a small FIFO, packs `PACK` consecutive results into one output-memory word and writes the words to consecutive addresses starting at a base address latched on `start`. Per-filter and end-of-convolution markers force partial words to be flushed with a byte-lane mask. A single-cycle `done` pulse is raised once the final word has been accepted by memory.

## Interface
- `DATA_W`, 8, width of one convolution result (one lane).
- `PACK`, 4, results per memory word (power of two, ≥2).
- `ADDR_W`, 8, output memory address width.
- `FIFO_DEPTH`, 4, input buffer entries (power of two, ≥2).
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a run; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address, latched with `start`.
- `res_valid`  in  1  result present on `res_data`.
- `res_data`  in  DATA_W  result value.
- `res_fend`  in  1  this result is the last of the current filter.
- `res_cend`  in  1  this result is the last of the whole convolution.
- `res_ready`  out  1  block can accept a result this cycle.
- `mem_wr_en`  out  1  write request valid.
- `mem_ready`  in  1  memory accepts the write this cycle.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wr_data`  out  PACK*DATA_W  packed word; lane i at bits [i*DATA_W +: DATA_W].
- `mem_wr_mask`  out  PACK  lane write enables.
- `words_written`  out  ADDR_W  words accepted by memory in current/last run.
- `done`  out  1  one-cycle pulse at end of run.

## Operation
- States: IDLE, RUN, DONE. IDLE→RUN on `start` (latch `base_addr`, clear address offset, lane counter, `words_written`). RUN→DONE at the edge where the word carrying a `res_cend` result is accepted (`mem_wr_en && mem_ready`). DONE→IDLE unconditionally after one cycle; `done`=1 exactly in DONE.
- `start` outside IDLE ignored. `res_ready` = (state==RUN) && FIFO not full; results offered in IDLE/DONE are not accepted.
- FIFO stores {data, fend, cend}; push on `res_valid && res_ready`. No bypass: a pushed entry is poppable from the next cycle.
- Pop allowed in RUN when FIFO non-empty and (`!mem_wr_en || mem_ready`). Popped data written to lane `lane_cnt`, mask bit set, `lane_cnt` increments.
- Word completes on pop when `lane_cnt==PACK-1` or entry has fend or cend: staging lanes and mask transferred into output registers, `mem_wr_en` set, `lane_cnt`←0, staging cleared. Unfilled lanes drive 0 with mask 0.
- `mem_addr` = `base_addr` + offset (mod 2^ADDR_W, wraps silently); offset and `words_written` increment on each accepted write. `words_written` holds after DONE until next `start`.
- `mem_wr_en && !mem_ready`: address, data, mask held stable; pops stall; FIFO continues filling up to full.
- Entries popped after a cend entry in the same run: none expected; any left in FIFO are discarded on `start` (FIFO cleared).
- Asynchronous reset (`rst_n`=0) at any time: state IDLE, FIFO empty, all outputs 0 (`res_ready`, `mem_wr_en`, `mem_addr`, `mem_wr_data`, `mem_wr_mask`, `words_written`, `done`); an in-flight write is dropped.

## Timing
- Result sampled at edge k into empty FIFO → popped at edge k+1 → if it completes a word, `mem_wr_en`=1 in cycle after edge k+1.
- With `mem_ready` held 1, sustained throughput one result per cycle; one word per PACK cycles; back-to-back words need no idle cycle.
- `done` high the cycle after the final write acceptance edge; `res_ready` low from that edge.
- `res_ready` reacts to full in the same cycle (combinational from registered count); simultaneous push and pop when full is not possible (ready low).

## Test plan
- Reset mid-write: `mem_wr_en`=1, drop `rst_n` → all outputs 0 immediately, state IDLE, next `start` resumes cleanly.
- `base_addr`=0x10, 8 results 1..8, last with cend, `mem_ready`=1 → writes 0x10: data 0x04030201 mask 0xF, 0x11: 0x08070605 mask 0xF; `done` one cycle; `words_written`=2.
- 6 results, 3rd has fend, 6th cend → 0x00030201 mask 0x7, then 0x00060504 mask 0x7; address increments per write.
- `mem_ready`=0 for 10 cycles during a write with continuous `res_valid` → write fields stable, `res_ready` falls after FIFO_DEPTH pushes, no result lost or duplicated after release.
- `base_addr`=0xFF, 8 results → writes at 0xFF then 0x00 (wrap).
- `start` pulsed during RUN and results offered in IDLE → ignored / not accepted (`res_ready`=0).

Source files
------------

// File: rtl/conv_result_writer.sv
// conv_result_writer: buffers finished convolution results in a small FIFO,
// packs PACK results per output word (lane 0 in the low bits) and writes the
// words to consecutive addresses from a latched base. Filter and convolution
// end markers flush partial words with a lane mask. The run ends with a
// one-cycle done pulse once the word holding the final result is accepted.
module conv_result_writer #(
    parameter int DATA_W     = 8,
    parameter int PACK       = 4,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic                   res_valid,
    input  logic [DATA_W-1:0]      res_data,
    input  logic                   res_fend,
    input  logic                   res_cend,
    output logic                   res_ready,
    output logic                   mem_wr_en,
    input  logic                   mem_ready,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [PACK*DATA_W-1:0] mem_wr_data,
    output logic [PACK-1:0]        mem_wr_mask,
    output logic [ADDR_W-1:0]      words_written,
    output logic                   done
);

    localparam int WORD_W  = PACK * DATA_W;
    localparam int LANE_W  = $clog2(PACK);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q;
    logic [ENTRY_W-1:0]  fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;
    logic [LANE_W-1:0]   lane_q;
    logic [WORD_W-1:0]   stage_data_q;
    logic [WORD_W-1:0]   stage_data_d;
    logic [PACK-1:0]     stage_mask_q;
    logic [PACK-1:0]     stage_mask_d;
    logic                wr_en_q;
    logic                cend_q;
    logic                done_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   words_q;
    logic [WORD_W-1:0]   data_q;
    logic [PACK-1:0]     mask_q;

    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                ready_s;
    logic                push_s;
    logic                pop_s;
    logic                accept_s;
    logic                word_done_s;
    logic [ENTRY_W-1:0]  head_s;
    logic [DATA_W-1:0]   head_data_s;
    logic                head_fend_s;
    logic                head_cend_s;

    // Handshake decisions and the staging word with the FIFO head merged in.
    always_comb begin
        fifo_full_s  = (count_q == CNT_W'(FIFO_DEPTH));
        fifo_empty_s = (count_q == {CNT_W{1'b0}});
        ready_s      = (state_q == ST_RUN) && !fifo_full_s;
        push_s       = res_valid && ready_s;
        accept_s     = wr_en_q && mem_ready;
        // A pending word carrying the end-of-convolution marker blocks further
        // pops so nothing can slip in behind the final word of the run.
        pop_s        = (state_q == ST_RUN) && !fifo_empty_s
                       && (!wr_en_q || mem_ready) && !(wr_en_q && cend_q);
        head_s       = fifo_q[rd_ptr_q];
        head_data_s  = head_s[ENTRY_W-1:2];
        head_fend_s  = head_s[1];
        head_cend_s  = head_s[0];
        stage_data_d = stage_data_q;
        stage_data_d[int'(lane_q)*DATA_W +: DATA_W] = head_data_s;
        stage_mask_d = stage_mask_q;
        stage_mask_d[lane_q] = 1'b1;
        word_done_s  = (lane_q == LANE_W'(PACK-1)) || head_fend_s || head_cend_s;
        count_d      = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // FIFO storage: {data, fend, cend} written at the write pointer on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= {ENTRY_W{1'b0}};
            end
        end else if (push_s) begin
            fifo_q[wr_ptr_q] <= {res_data, res_fend, res_cend};
        end
    end

    // Run control FSM with FIFO pointers, lane packing and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            lane_q       <= {LANE_W{1'b0}};
            stage_data_q <= {WORD_W{1'b0}};
            stage_mask_q <= {PACK{1'b0}};
            wr_en_q      <= 1'b0;
            cend_q       <= 1'b0;
            done_q       <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            words_q      <= {ADDR_W{1'b0}};
            data_q       <= {WORD_W{1'b0}};
            mask_q       <= {PACK{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_RUN;
                        addr_q       <= base_addr;
                        words_q      <= {ADDR_W{1'b0}};
                        lane_q       <= {LANE_W{1'b0}};
                        stage_data_q <= {WORD_W{1'b0}};
                        stage_mask_q <= {PACK{1'b0}};
                        wr_ptr_q     <= {PTR_W{1'b0}};
                        rd_ptr_q     <= {PTR_W{1'b0}};
                        count_q      <= {CNT_W{1'b0}};
                        wr_en_q      <= 1'b0;
                        cend_q       <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (push_s) begin
                        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                    end
                    if (pop_s) begin
                        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                    end
                    count_q <= count_d;
                    if (accept_s) begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        words_q <= words_q + ADDR_W'(1);
                    end
                    if (pop_s && word_done_s) begin
                        data_q       <= stage_data_d;
                        mask_q       <= stage_mask_d;
                        wr_en_q      <= 1'b1;
                        cend_q       <= head_cend_s;
                        lane_q       <= {LANE_W{1'b0}};
                        stage_data_q <= {WORD_W{1'b0}};
                        stage_mask_q <= {PACK{1'b0}};
                    end else begin
                        if (pop_s) begin
                            stage_data_q <= stage_data_d;
                            stage_mask_q <= stage_mask_d;
                            lane_q       <= lane_q + LANE_W'(1);
                        end
                        if (accept_s) begin
                            wr_en_q <= 1'b0;
                        end
                    end
                    if (accept_s && cend_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign res_ready     = ready_s;
    assign mem_wr_en     = wr_en_q;
    assign mem_addr      = addr_q;
    assign mem_wr_data   = data_q;
    assign mem_wr_mask   = mask_q;
    assign words_written = words_q;
    assign done          = done_q;

endmodule

// File: tb/tb_conv_result_writer.sv
// Bench for conv_result_writer: directed cases plus randomized runs, with a
// scoreboard that packs accepted results into expected words.
module tb_conv_result_writer;

    localparam int DATA_W     = 8;
    localparam int PACK       = 4;
    localparam int ADDR_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int WORD_W     = PACK * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_fend;
    logic              res_cend;
    logic              res_ready;
    logic              mem_wr_en;
    logic              mem_ready = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wr_data;
    logic [PACK-1:0]   mem_wr_mask;
    logic [ADDR_W-1:0] words_written;
    logic              done;

    conv_result_writer #(
        .DATA_W(DATA_W), .PACK(PACK), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .res_valid(res_valid), .res_data(res_data), .res_fend(res_fend),
        .res_cend(res_cend), .res_ready(res_ready), .mem_wr_en(mem_wr_en),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_mask(mem_wr_mask), .words_written(words_written), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
        logic [PACK-1:0]   mask;
        bit                cend;
    } word_t;

    typedef enum {M_IDLE, M_RUN, M_DONE} mstate_e;

    word_t             exp_q[$];
    word_t             wlog[$];
    mstate_e           m_state = M_IDLE;
    logic [ADDR_W-1:0] m_base = '0;
    int                m_built = 0;
    int                m_words = 0;
    int                m_n = 0;
    logic [DATA_W-1:0] m_lanes [PACK];

    task automatic model_push(input logic [DATA_W-1:0] d, input bit f, input bit c);
        word_t w;
        m_lanes[m_n] = d;
        m_n++;
        if (m_n == PACK || f || c) begin
            w.data = '0;
            w.mask = '0;
            for (int i = 0; i < m_n; i++) begin
                w.data = w.data | (WORD_W'(m_lanes[i]) << (i * DATA_W));
                w.mask[i] = 1'b1;
            end
            w.addr = m_base + ADDR_W'(m_built);
            w.cend = c;
            m_built++;
            m_n = 0;
            exp_q.push_back(w);
        end
    endtask

    // Monitor: samples handshakes mid-cycle, updates the model, checks writes.
    always @(negedge clk) begin
        word_t w;
        word_t e;
        mstate_e prev;
        if (!rst_n) begin
            m_state = M_IDLE;
            m_built = 0;
            m_words = 0;
            m_n     = 0;
            exp_q.delete();
        end else begin
            prev = m_state;
            chk_eq("done", done, (prev == M_DONE));
            chk_eq("words_written", words_written, ADDR_W'(m_words));
            if (prev != M_RUN) chk_eq("res_ready_not_run", res_ready, 1'b0);
            if (res_valid && res_ready) model_push(res_data, res_fend, res_cend);
            if (mem_wr_en && mem_ready) begin
                w.addr = mem_addr;
                w.data = mem_wr_data;
                w.mask = mem_wr_mask;
                w.cend = 1'b0;
                wlog.push_back(w);
                if (exp_q.size() == 0) begin
                    chk_eq("unexpected_write", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk_eq("wr_addr", mem_addr, e.addr);
                    chk_eq("wr_data", mem_wr_data, e.data);
                    chk_eq("wr_mask", mem_wr_mask, e.mask);
                    m_words++;
                    if (e.cend) m_state = M_DONE;
                end
            end
            if (prev == M_DONE) begin
                m_state = M_IDLE;
            end else if (prev == M_IDLE && start) begin
                chk_eq("start_exp_empty", exp_q.size(), 0);
                m_state = M_RUN;
                m_base  = base_addr;
                m_built = 0;
                m_words = 0;
                m_n     = 0;
                wlog.delete();
            end
        end
    end

    // Memory ready generator: 0 = always ready, 1 = random, 2 = held off.
    int mr_mode = 0;
    always @(posedge clk) begin
        #1;
        case (mr_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = ($urandom_range(0, 3) != 0);
            default: mem_ready = 1'b0;
        endcase
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start(input logic [ADDR_W-1:0] b);
        base_addr = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = ADDR_W'($urandom);
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input bit f, input bit c, input int max_gap);
        bit acc;
        acc = 1'b0;
        repeat ($urandom_range(0, max_gap)) begin
            res_valid = 1'b0;
            @(posedge clk); #1;
        end
        res_data  = d;
        res_fend  = f;
        res_cend  = c;
        res_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (res_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        res_valid = 1'b0;
        res_fend  = 1'b0;
        res_cend  = 1'b0;
        chk_eq("send_accepted", acc, 1'b1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk_eq("done_seen", seen, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic chk_word(input string tag, input int idx, input logic [ADDR_W-1:0] a,
                            input logic [WORD_W-1:0] d, input logic [PACK-1:0] m);
        if (idx < wlog.size()) begin
            chk_eq({tag, "_addr"}, wlog[idx].addr, a);
            chk_eq({tag, "_data"}, wlog[idx].data, d);
            chk_eq({tag, "_mask"}, wlog[idx].mask, m);
        end else begin
            chk_eq({tag, "_missing"}, wlog.size(), idx + 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int n;
        rst_n = 1'b0; start = 1'b0; base_addr = '0;
        res_valid = 1'b0; res_data = '0; res_fend = 1'b0; res_cend = 1'b0;
        #3;
        chk_eq("rst_res_ready", res_ready, 1'b0);
        chk_eq("rst_wr_en", mem_wr_en, 1'b0);
        chk_eq("rst_addr", mem_addr, 8'h00);
        chk_eq("rst_data", mem_wr_data, 32'h0);
        chk_eq("rst_mask", mem_wr_mask, 4'h0);
        chk_eq("rst_words", words_written, 8'h00);
        chk_eq("rst_done", done, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Two full words from base 0x10.
        mr_mode = 0;
        do_start(8'h10);
        for (int i = 1; i <= 8; i++) send(DATA_W'(i), 1'b0, (i == 8), 0);
        wait_done();
        chk_word("a0", 0, 8'h10, 32'h04030201, 4'hF);
        chk_word("a1", 1, 8'h11, 32'h08070605, 4'hF);
        chk_eq("a_words", words_written, 8'd2);

        // Filter end flushes partial words; start pulse mid-run is ignored.
        do_start(8'h00);
        for (int i = 1; i <= 6; i++) begin
            send(DATA_W'(i), (i == 3), (i == 6), 1);
            if (i == 2) begin
                start = 1'b1; base_addr = 8'hA0;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        wait_done();
        chk_word("b0", 0, 8'h00, 32'h00030201, 4'h7);
        chk_word("b1", 1, 8'h01, 32'h00060504, 4'h7);

        // Results offered while idle are refused.
        res_valid = 1'b1; res_data = 8'hEE; res_cend = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_eq("idle_ready", res_ready, 1'b0);
            @(posedge clk); #1;
        end
        res_valid = 1'b0; res_cend = 1'b0;

        // Reset while a write is pending.
        mr_mode = 2;
        do_start(8'h30);
        for (int i = 1; i <= 4; i++) send(DATA_W'(8'h50 + i), 1'b0, 1'b0, 0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mem_wr_en) seen = 1'b1;
        end
        chk_eq("pre_reset_wr_en", seen, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_res_ready", res_ready, 1'b0);
        chk_eq("mid_rst_wr_en", mem_wr_en, 1'b0);
        chk_eq("mid_rst_addr", mem_addr, 8'h00);
        chk_eq("mid_rst_data", mem_wr_data, 32'h0);
        chk_eq("mid_rst_mask", mem_wr_mask, 4'h0);
        chk_eq("mid_rst_words", words_written, 8'h00);
        chk_eq("mid_rst_done", done, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        mr_mode = 0;
        @(posedge clk); #1;

        // Address wrap from 0xFF after reset.
        do_start(8'hFF);
        for (int i = 1; i <= 8; i++) send(DATA_W'(i), 1'b0, (i == 8), 0);
        wait_done();
        chk_word("e0", 0, 8'hFF, 32'h04030201, 4'hF);
        chk_word("e1", 1, 8'h00, 32'h08070605, 4'hF);

        // Memory back-pressure: write fields hold, FIFO fills, then drains.
        mr_mode = 2;
        do_start(8'h40);
        for (int i = 1; i <= 8; i++) send(DATA_W'(i), 1'b0, 1'b0, 0);
        res_data = 8'h09; res_fend = 1'b0; res_cend = 1'b0; res_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_eq("stall_ready", res_ready, 1'b0);
            chk_eq("stall_wr_en", mem_wr_en, 1'b1);
            chk_eq("stall_addr", mem_addr, 8'h40);
            chk_eq("stall_data", mem_wr_data, 32'h04030201);
            chk_eq("stall_mask", mem_wr_mask, 4'hF);
        end
        mr_mode = 0;
        for (int i = 9; i <= 12; i++) send(DATA_W'(i), 1'b0, (i == 12), 0);
        wait_done();
        chk_eq("d_words", words_written, 8'd3);
        chk_word("d0", 0, 8'h40, 32'h04030201, 4'hF);
        chk_word("d1", 1, 8'h41, 32'h08070605, 4'hF);
        chk_word("d2", 2, 8'h42, 32'h0C0B0A09, 4'hF);

        // Randomized runs with random memory back-pressure and input gaps.
        mr_mode = 1;
        for (int r = 0; r < 10; r++) begin
            do_start(ADDR_W'($urandom));
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) begin
                send(DATA_W'($urandom), ($urandom_range(0, 4) == 0), (i == n - 1), 2);
            end
            wait_done();
            chk_eq("rand_leftover", exp_q.size(), 0);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
